// File: rtl/recirculacion_param.sv
// recirculacion_param: registered, parametrised probe-side recirculation demux.
// Each cycle the LANES data/valid lanes are registered either onto the forward
// (_rf) side or back to the prober (_rp) side. Forwarding needs IDLE_OUT held
// high for IDLE_SYNC consecutive edges; any low IDLE_OUT drops back at once.
// Optional feature macro: RECIRC_CNT_EN builds the saturating count of
// recirculated valid words; when undefined recirc_cnt is tied to zero.
module recirculacion_param #(
    parameter int unsigned LANES     = 4,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned IDLE_SYNC = 2,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [LANES*DATA_W-1:0] data_ps,
    input  logic [LANES-1:0]        valid_ps,
    input  logic                    IDLE_OUT,
    output logic [LANES*DATA_W-1:0] data_rf,
    output logic [LANES-1:0]        valid_rf,
    output logic [LANES*DATA_W-1:0] data_rp,
    output logic [LANES-1:0]        valid_rp,
    output logic                    mode_fwd,
    output logic [CNT_W-1:0]        recirc_cnt
);

    localparam int unsigned BUS_W = LANES * DATA_W;
    localparam int unsigned ARM_W = (IDLE_SYNC > 1) ? $clog2(IDLE_SYNC) : 1;
    localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(IDLE_SYNC - 1);

    typedef enum logic {
        ST_RECIRC = 1'b0,
        ST_FWD    = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ARM_W-1:0]  arm_cnt;
    logic [ARM_W-1:0]  arm_cnt_nxt;
    logic              route_fwd_c;

    // State register and idle-run arm counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_RECIRC;
            arm_cnt <= '0;
        end else begin
            state   <= state_nxt;
            arm_cnt <= arm_cnt_nxt;
        end
    end

    // Next state: arm on consecutive idle cycles, leave FWD on the first busy one
    always_comb begin
        state_nxt   = state;
        arm_cnt_nxt = '0;
        unique case (state)
            ST_RECIRC: begin
                if (IDLE_OUT) begin
                    if (arm_cnt == ARM_LAST) begin
                        state_nxt   = ST_FWD;
                        arm_cnt_nxt = '0;
                    end else begin
                        arm_cnt_nxt = arm_cnt + ARM_W'(1);
                    end
                end
            end
            ST_FWD: begin
                if (!IDLE_OUT) begin
                    state_nxt = ST_RECIRC;
                end
            end
            default: begin
                state_nxt = ST_RECIRC;
            end
        endcase
    end

    // Route select: never forward in a cycle where downstream is busy
    always_comb begin
        route_fwd_c = 1'b0;
        if (state == ST_FWD) begin
            route_fwd_c = IDLE_OUT;
        end
    end

    assign mode_fwd = (state == ST_FWD);

    // Output registers: selected side takes the input, the other side is zeroed
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_rf  <= '0;
            valid_rf <= '0;
            data_rp  <= '0;
            valid_rp <= '0;
        end else if (route_fwd_c) begin
            data_rf  <= data_ps;
            valid_rf <= valid_ps;
            data_rp  <= BUS_W'(0);
            valid_rp <= LANES'(0);
        end else begin
            data_rf  <= BUS_W'(0);
            valid_rf <= LANES'(0);
            data_rp  <= data_ps;
            valid_rp <= valid_ps;
        end
    end

`ifdef RECIRC_CNT_EN
    localparam int unsigned POP_W = $clog2(LANES + 1);
    localparam int unsigned SUM_W = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [POP_W-1:0] pop_c;
    logic [SUM_W-1:0] sum_c;
    logic [CNT_W-1:0] cnt_sat_c;

    // Number of valid lanes in the current input word
    always_comb begin
        pop_c = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            pop_c = pop_c + POP_W'(valid_ps[i]);
        end
    end

    // Saturating add of the valid-lane count
    always_comb begin
        sum_c     = SUM_W'(recirc_cnt) + SUM_W'(pop_c);
        cnt_sat_c = recirc_cnt;
        if (sum_c > SUM_W'(CNT_MAX)) begin
            cnt_sat_c = CNT_MAX;
        end else begin
            cnt_sat_c = CNT_W'(sum_c);
        end
    end

    // Count valid words only on recirculated cycles; cleared by reset alone
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            recirc_cnt <= '0;
        end else if (!route_fwd_c) begin
            recirc_cnt <= cnt_sat_c;
        end
    end
`else
    assign recirc_cnt = '0;
`endif

endmodule

// File: tb/tb_recirculacion_param.sv
// Bench for recirculacion_param: a default instance, a CNT_W=4 instance on the
// same stimulus, and a LANES=1/DATA_W=16/IDLE_SYNC=1 instance on lane 0.
module tb_recirculacion_param;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] data_ps;
    logic [3:0]  valid_ps;
    logic        idle_out;

    logic [31:0] data_rf0, data_rp0, data_rf2, data_rp2;
    logic [3:0]  valid_rf0, valid_rp0, valid_rf2, valid_rp2;
    logic        mode0, mode2;
    logic [15:0] cnt0;
    logic [3:0]  cnt2;

    logic [15:0] data_rf1, data_rp1;
    logic        valid_rf1, valid_rp1, mode1;
    logic [3:0]  cnt1;

    always #5 clk = ~clk;

    recirculacion_param dut0 (
        .clk(clk), .reset(reset), .data_ps(data_ps), .valid_ps(valid_ps),
        .IDLE_OUT(idle_out), .data_rf(data_rf0), .valid_rf(valid_rf0),
        .data_rp(data_rp0), .valid_rp(valid_rp0), .mode_fwd(mode0),
        .recirc_cnt(cnt0)
    );

    recirculacion_param #(.CNT_W(4)) dut2 (
        .clk(clk), .reset(reset), .data_ps(data_ps), .valid_ps(valid_ps),
        .IDLE_OUT(idle_out), .data_rf(data_rf2), .valid_rf(valid_rf2),
        .data_rp(data_rp2), .valid_rp(valid_rp2), .mode_fwd(mode2),
        .recirc_cnt(cnt2)
    );

    recirculacion_param #(.LANES(1), .DATA_W(16), .IDLE_SYNC(1), .CNT_W(4)) dut1 (
        .clk(clk), .reset(reset), .data_ps(data_ps[15:0]), .valid_ps(valid_ps[0]),
        .IDLE_OUT(idle_out), .data_rf(data_rf1), .valid_rf(valid_rf1),
        .data_rp(data_rp1), .valid_rp(valid_rp1), .mode_fwd(mode1),
        .recirc_cnt(cnt1)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: forwarding allowed once the current run of idle edges
    // reaches the sync length; counters are plain saturating sums.
    int run_len = 0;
    int m_cnt0 = 0, m_cnt1 = 0, m_cnt2 = 0;
    logic [31:0] e_rf0, e_rp0;
    logic [3:0]  e_vrf0, e_vrp0;
    logic        e_mode0;
    logic [15:0] e_rf1, e_rp1;
    logic        e_vrf1, e_vrp1, e_mode1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat_add(input int a, input int b, input int maxv);
        return (a + b > maxv) ? maxv : a + b;
    endfunction

    task automatic model_reset();
        run_len = 0;
        m_cnt0 = 0; m_cnt1 = 0; m_cnt2 = 0;
    endtask

    task automatic check_model(input string tag);
        int ec0, ec1, ec2;
`ifdef RECIRC_CNT_EN
        ec0 = m_cnt0; ec1 = m_cnt1; ec2 = m_cnt2;
`else
        ec0 = 0; ec1 = 0; ec2 = 0;
`endif
        chk({tag, ".rf0"},   64'(data_rf0),  64'(e_rf0));
        chk({tag, ".vrf0"},  64'(valid_rf0), 64'(e_vrf0));
        chk({tag, ".rp0"},   64'(data_rp0),  64'(e_rp0));
        chk({tag, ".vrp0"},  64'(valid_rp0), 64'(e_vrp0));
        chk({tag, ".mode0"}, 64'(mode0),     64'(e_mode0));
        chk({tag, ".cnt0"},  64'(cnt0),      64'(ec0));
        chk({tag, ".cnt2"},  64'(cnt2),      64'(ec2));
        chk({tag, ".rf1"},   64'(data_rf1),  64'(e_rf1));
        chk({tag, ".vrf1"},  64'(valid_rf1), 64'(e_vrf1));
        chk({tag, ".rp1"},   64'(data_rp1),  64'(e_rp1));
        chk({tag, ".vrp1"},  64'(valid_rp1), 64'(e_vrp1));
        chk({tag, ".mode1"}, 64'(mode1),     64'(e_mode1));
    endtask

    // Apply one input word at the falling edge, let one rising edge pass, check
    task automatic step(input string tag, input logic idle, input logic [31:0] d,
                        input logic [3:0] v);
        logic fwd0, fwd1;
        idle_out = idle;
        data_ps  = d;
        valid_ps = v;
        fwd0 = idle && (run_len >= 2);
        fwd1 = idle && (run_len >= 1);
        run_len = idle ? ((run_len < 1000) ? run_len + 1 : run_len) : 0;
        e_rf0  = fwd0 ? d : 32'h0;
        e_vrf0 = fwd0 ? v : 4'h0;
        e_rp0  = fwd0 ? 32'h0 : d;
        e_vrp0 = fwd0 ? 4'h0 : v;
        e_mode0 = (run_len >= 2);
        e_rf1  = fwd1 ? d[15:0] : 16'h0;
        e_vrf1 = fwd1 ? v[0] : 1'b0;
        e_rp1  = fwd1 ? 16'h0 : d[15:0];
        e_vrp1 = fwd1 ? 1'b0 : v[0];
        e_mode1 = (run_len >= 1);
        if (!fwd0) begin
            m_cnt0 = sat_add(m_cnt0, $countones(v), 65535);
            m_cnt2 = sat_add(m_cnt2, $countones(v), 15);
        end
        if (!fwd1) m_cnt1 = sat_add(m_cnt1, int'(v[0]), 15);
        @(posedge clk);
        @(negedge clk);
        check_model(tag);
    endtask

    // Mid-stream asynchronous reset: outputs must clear without a clock edge
    task automatic do_reset(input string tag);
        reset = 1'b1;
        #1;
        chk({tag, ".rf0"},  64'(data_rf0),  64'h0);
        chk({tag, ".vrf0"}, 64'(valid_rf0), 64'h0);
        chk({tag, ".rp0"},  64'(data_rp0),  64'h0);
        chk({tag, ".vrp0"}, 64'(valid_rp0), 64'h0);
        chk({tag, ".mode0"}, 64'(mode0),    64'h0);
        chk({tag, ".cnt0"}, 64'(cnt0),      64'h0);
        chk({tag, ".rf1"},  64'(data_rf1),  64'h0);
        chk({tag, ".mode1"}, 64'(mode1),    64'h0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        logic        idle;
        logic [31:0] data;
        logic [3:0]  valid;
        logic [31:0] e_rf;
        logic [3:0]  e_vrf;
        logic [31:0] e_rp;
        logic [3:0]  e_vrp;
        logic        e_mode;
    } vec_t;

    vec_t tbl [9];

    initial begin
        // Directed vectors for the default instance (IDLE_SYNC=2)
        tbl[0] = '{1'b0, 32'h44332211, 4'hF, 32'h0, 4'h0, 32'h44332211, 4'hF, 1'b0};
        tbl[1] = '{1'b1, 32'hA0A0A0A0, 4'hF, 32'h0, 4'h0, 32'hA0A0A0A0, 4'hF, 1'b0};
        tbl[2] = '{1'b1, 32'hA1A1A1A1, 4'hF, 32'h0, 4'h0, 32'hA1A1A1A1, 4'hF, 1'b1};
        tbl[3] = '{1'b1, 32'hA2A2A2A2, 4'hF, 32'hA2A2A2A2, 4'hF, 32'h0, 4'h0, 1'b1};
        tbl[4] = '{1'b0, 32'hDEADBEEF, 4'hF, 32'h0, 4'h0, 32'hDEADBEEF, 4'hF, 1'b0};
        tbl[5] = '{1'b1, 32'hA3A3A3A3, 4'hF, 32'h0, 4'h0, 32'hA3A3A3A3, 4'hF, 1'b0};
        tbl[6] = '{1'b1, 32'hA4A4A4A4, 4'hF, 32'h0, 4'h0, 32'hA4A4A4A4, 4'hF, 1'b1};
        tbl[7] = '{1'b1, 32'hA5A5A5A5, 4'h5, 32'hA5A5A5A5, 4'h5, 32'h0, 4'h0, 1'b1};
        tbl[8] = '{1'b1, 32'h12345678, 4'h0, 32'h12345678, 4'h0, 32'h0, 4'h0, 1'b1};

        reset    = 1'b1;
        idle_out = 1'b0;
        data_ps  = 32'h0;
        valid_ps = 4'h0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst.rf0",   64'(data_rf0), 64'h0);
        chk("rst.rp0",   64'(data_rp0), 64'h0);
        chk("rst.mode0", 64'(mode0),    64'h0);
        chk("rst.cnt0",  64'(cnt0),     64'h0);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            step($sformatf("tbl%0d", i), tbl[i].idle, tbl[i].data, tbl[i].valid);
            chk($sformatf("tbl%0d.rf", i),   64'(data_rf0),  64'(tbl[i].e_rf));
            chk($sformatf("tbl%0d.vrf", i),  64'(valid_rf0), 64'(tbl[i].e_vrf));
            chk($sformatf("tbl%0d.rp", i),   64'(data_rp0),  64'(tbl[i].e_rp));
            chk($sformatf("tbl%0d.vrp", i),  64'(valid_rp0), 64'(tbl[i].e_vrp));
            chk($sformatf("tbl%0d.mode", i), 64'(mode0),     64'(tbl[i].e_mode));
        end

        // Reset in the middle of forwarding traffic
        idle_out = 1'b1;
        valid_ps = 4'hF;
        data_ps  = 32'h55AA55AA;
        do_reset("t1");

        // Counter: three recirculated words of 4'b1011
        for (int i = 0; i < 3; i++) step("t5a", 1'b0, 32'h01020304 + 32'(i), 4'b1011);
`ifdef RECIRC_CNT_EN
        chk("t5.cnt9", 64'(cnt0), 64'd9);
`else
        chk("t5.cnt9", 64'(cnt0), 64'd0);
`endif

        // Counter saturation on the 4-bit instance
        do_reset("t5r");
        for (int i = 0; i < 5; i++) step("t5b", 1'b0, 32'hCAFE0000 + 32'(i), 4'hF);
`ifdef RECIRC_CNT_EN
        chk("t5.sat15", 64'(cnt2), 64'd15);
        chk("t5.cnt20", 64'(cnt0), 64'd20);
`else
        chk("t5.sat15", 64'(cnt2), 64'd0);
        chk("t5.cnt20", 64'(cnt0), 64'd0);
`endif

        // Single-lane, IDLE_SYNC=1 instance forwards after one idle edge
        step("t6a", 1'b0, 32'h0000BEEF, 4'h1);
        step("t6b", 1'b1, 32'h0000BEEF, 4'h1);
        chk("t6.rp1",   64'(data_rp1), 64'hBEEF);
        chk("t6.mode1", 64'(mode1),    64'h1);
        step("t6c", 1'b1, 32'h0000BEEF, 4'h1);
        chk("t6.rf1",   64'(data_rf1), 64'hBEEF);
        chk("t6.vrf1",  64'(valid_rf1), 64'h1);
        chk("t6.rp1z",  64'(data_rp1), 64'h0);

        // Randomised traffic, idle-biased so both modes and glitches occur
        for (int i = 0; i < 400; i++) begin
            step("rnd", ($urandom_range(0, 4) != 0), $urandom, 4'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
